// File: rtl/ram_burst_reader_pkg.sv
// Shared constants for the RAM burst reader: FSM encoding, skid FIFO sizing
// and default widths matching the attached single-cycle-latency RAM.
package ram_burst_reader_pkg;
  localparam int ADDR_LEN_DEF = 16;
  localparam int DATA_LEN_DEF = 8;
  localparam int RD_LATENCY   = 1;
  // One slot per cycle of read latency plus one so a stalled head never blocks issue.
  localparam int FIFO_DEPTH   = RD_LATENCY + 1;
  localparam int FIFO_CW      = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PW      = $clog2(FIFO_DEPTH);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry skid FIFO turning the fixed-latency RAM Q stream into a
// valid/ready stream; head entry is presented directly on data_o.
module ram_rd_skid_fifo
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic                pop_i,
  output logic [DATA_LEN-1:0] data_o,
  output logic [FIFO_CW-1:0]  count_o,
  output logic                empty_o
);
  logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_CW-1:0]  count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + FIFO_CW'(push_i) - FIFO_CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  // Full with a simultaneous pop is fine; full without one would drop a word.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && count_q == FIFO_CW'(FIFO_DEPTH)));
endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master for a registered-Q RAM: issues sequential reads under a
// credit rule so the skid FIFO never overflows, and streams words out.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [ADDR_LEN:0]   len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] rd_addr,
  input  logic [DATA_LEN-1:0] Q,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam logic [ADDR_LEN:0] CNT_ONE = (ADDR_LEN+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] ptr_q, ptr_d, last_addr_q, last_addr_d;
  logic [ADDR_LEN:0]   issue_cnt_q, issue_cnt_d, recv_cnt_q, recv_cnt_d;
  logic                inflight_q, done_q, done_d;
  logic [FIFO_CW-1:0]  fifo_cnt;
  logic [FIFO_CW:0]    occ;
  logic                fifo_empty, pop, issue;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // Occupancy after this cycle's pop must leave room for the read issued now.
  assign occ   = (FIFO_CW+1)'(fifo_cnt) + (FIFO_CW+1)'(inflight_q) - (FIFO_CW+1)'(pop);
  assign issue = (state_q == ST_ISSUE) && (occ < (FIFO_CW+1)'(FIFO_DEPTH));

  assign rd_addr = issue ? ptr_q : last_addr_q;
  assign busy    = (state_q != ST_IDLE) || done_q;
  assign done    = done_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_addr_d = last_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    done_d      = 1'b0;
    if (pop) recv_cnt_d = recv_cnt_q - CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          if (len != '0) begin
            ptr_d       = base_addr;
            issue_cnt_d = len;
            recv_cnt_d  = len;
            state_d     = ST_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          ptr_d       = ptr_q + 1'b1;
          last_addr_d = ptr_q;
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          if (issue_cnt_q == CNT_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && recv_cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      last_addr_q <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_addr_q <= last_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      inflight_q  <= issue;
      done_q      <= done_d;
    end
  end

  ram_rd_skid_fifo #(.DATA_LEN(DATA_LEN)) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (inflight_q),
    .data_i (Q),
    .pop_i  (pop),
    .data_o (out_data),
    .count_o(fifo_cnt),
    .empty_o(fifo_empty)
  );
endmodule
